// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI serial-memory responder: default opcodes,
// the fixed length of the address phase, and the responder state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;

    // The address phase is always two bytes on the wire, whatever ADDR_W is.
    localparam int SPI_ADDR_PHASE_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_IGNORE  = 3'd6
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for one asynchronous input plus single-cycle rise and
// fall pulses derived from the synchronized level.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   d_in   in   asynchronous input
//   level  out  synchronized level
//   rise   out  one-clk pulse on synchronized 0->1
//   fall   out  one-clk pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    // Idle level of the input; loading it at reset avoids a false edge
    // when the first real sample arrives.
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// -----------------------------------------------------------------------------
// spi_mem_responder
// SPI mode-0 target emulating a 23LC-style serial SRAM. Decodes READ/WRITE
// plus a 16-bit address, then streams bytes with address auto-increment,
// bridged to a synchronous parallel memory port (1-cycle read latency).
// Ports:
//   clk, rst               system clock (>= 4x sclk), async active-high reset
//   cs_n, sclk, mosi       SPI link inputs, asynchronous to clk
//   miso, miso_oe          SPI data out and its drive enable (read data phase)
//   mem_addr               memory address, holds last value when idle
//   mem_re, mem_rdata      read strobe; data returned on the following clk
//   mem_we, mem_wdata      write strobe and data
//   busy                   high whenever the responder is not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for cs_n to fall
// ST_CMD     | shifting in the opcode byte
// ST_ADDR_HI | shifting in address bits 15:8
// ST_ADDR_LO | shifting in address bits 7:0
// ST_RD_DATA | streaming memory bytes out on miso
// ST_WR_DATA | shifting in bytes and writing them to memory
// ST_IGNORE  | unknown opcode, wait for cs_n to rise
// -----------------------------------------------------------------------------
module spi_mem_responder
    import spi_pkg::*;
#(
    parameter int         ADDR_W   = SPI_ADDR_PHASE_BITS,
    parameter logic [7:0] OP_READ  = SPI_OP_READ,
    parameter logic [7:0] OP_WRITE = SPI_OP_WRITE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    logic cs_n_s, cs_fall, cs_rise_unused;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_in(cs_n),
        .level(cs_n_s), .rise(cs_rise_unused), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_in(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Same synchronizer depth as sclk, so mosi_s is the value present at
    // the sclk rise that sclk_rise reports.
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_in(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              is_read_q, is_read_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              load_q, load_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;

    logic [7:0]        rx_byte;
    logic [7:0]        tx_src;
    logic [15:0]       addr_full;
    logic              last_bit;

    assign rx_byte   = {rx_q[6:0], mosi_s};
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign addr_full = {addr_hi_q, rx_byte};
    // Read data may arrive in the same clk as the sclk fall that must show
    // its MSB, so the shifter source bypasses straight from the memory.
    assign tx_src    = load_q ? mem_rdata : tx_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        is_read_d   = is_read_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        load_d      = mem_re_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;

        if (state_q != ST_IDLE && cs_n_s) begin
            // Deselect aborts everything; a partial write byte is dropped.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            load_d    = 1'b0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA, ST_RD_DATA: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            case (state_q)
                                ST_CMD: begin
                                    is_read_d = (rx_byte == OP_READ);
                                    if (rx_byte == OP_READ || rx_byte == OP_WRITE)
                                        state_d = ST_ADDR_HI;
                                    else
                                        state_d = ST_IGNORE;
                                end
                                ST_ADDR_HI: begin
                                    addr_hi_d = rx_byte;
                                    state_d   = ST_ADDR_LO;
                                end
                                ST_ADDR_LO: begin
                                    addr_d = addr_full[ADDR_W-1:0];
                                    if (is_read_q) begin
                                        state_d    = ST_RD_DATA;
                                        mem_re_d   = 1'b1;
                                        mem_addr_d = addr_full[ADDR_W-1:0];
                                    end else begin
                                        state_d = ST_WR_DATA;
                                    end
                                end
                                ST_WR_DATA: begin
                                    mem_we_d    = 1'b1;
                                    mem_wdata_d = rx_byte;
                                    mem_addr_d  = addr_q;
                                    addr_d      = addr_q + ADDR_W'(1);
                                end
                                ST_RD_DATA: begin
                                    // Prefetch the next byte so it is loaded
                                    // before the fall that shows its MSB.
                                    addr_d     = addr_q + ADDR_W'(1);
                                    mem_addr_d = addr_q + ADDR_W'(1);
                                    mem_re_d   = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase

            if (state_q == ST_RD_DATA) begin
                if (load_q) begin
                    tx_d      = mem_rdata;
                    miso_oe_d = 1'b1;
                end
                if (sclk_fall && (miso_oe_q || load_q)) begin
                    miso_d = tx_src[7];
                    tx_d   = {tx_src[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'd0;
            tx_q        <= 8'd0;
            addr_hi_q   <= 8'd0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            is_read_q   <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            is_read_q   <= is_read_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign miso      = miso_q & miso_oe_q;
    assign miso_oe   = miso_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_responder
// Drives the responder as an SPI mode-0 master against a byte-array memory
// and checks results against a plain reference memory image.
// -----------------------------------------------------------------------------
module tb_spi_mem_responder;

    localparam int HALF = 50;   // sclk half period, 5 clk periods

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;

    always #5 clk = ~clk;

    spi_mem_responder dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int viol = 0;
    int oe_cnt = 0;
    int we_applied = 0;

    logic [7:0]  env_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] re_log [$];
    logic [23:0] we_log [$];
    logic [7:0]  wbuf [0:15];
    logic [7:0]  rbuf [0:15];

    // Memory attached to the DUT's parallel port.
    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= env_mem[mem_addr];
            re_log.push_back(mem_addr);
        end
        if (mem_we)
            we_log.push_back({mem_addr, mem_wdata});
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re && mem_we) viol++;
            if (!miso_oe && miso) viol++;
            if (miso_oe) oe_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] we_at(input int i);
        if (i < we_log.size()) return we_log[i];
        return 24'hxxxxxx;
    endfunction

    function automatic logic [15:0] re_at(input int i);
        if (i < re_log.size()) return re_log[i];
        return 16'hxxxx;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Commit the DUT's writes into the attached memory so later reads see them.
    task automatic sync_env();
        for (int i = we_applied; i < we_log.size(); i++)
            env_mem[we_log[i][23:8]] = we_log[i][7:0];
        we_applied = we_log.size();
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #HALF;
            sclk = 1'b1;
            r[i] = miso;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic begin_xfer();
        @(negedge clk);
        cs_n = 1'b0;
        #(2*HALF);
    endtask

    task automatic end_xfer();
        #HALF;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] op, input logic [15:0] a, input int n);
        logic [7:0] d;
        begin_xfer();
        spi_bits(op, 8, d);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
        for (int i = 0; i < n; i++) begin
            spi_bits(wbuf[i], 8, d);
            rbuf[i] = d;
        end
        end_xfer();
    endtask

    initial begin
        int rb, wb, oe0, n;
        logic [15:0] a, ai;
        logic [7:0] d, v;
        logic is_rd;

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_miso", miso, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Single-byte write.
        rb = re_log.size(); wb = we_log.size();
        wbuf[0] = 8'hAB;
        xfer(8'h02, 16'h1234, 1);
        chk("wr1_count", we_log.size() - wb, 1);
        chk("wr1_addr", we_at(wb)[23:8], 16'h1234);
        chk("wr1_data", we_at(wb)[7:0], 8'hAB);
        chk("wr1_no_re", re_log.size() - rb, 0);
        chk("wr1_busy", busy, 0);
        ref_mem[16'h1234] = 8'hAB;
        sync_env();

        // Two-byte read.
        poke(16'h1234, 8'h5A);
        poke(16'h1235, 8'hC3);
        rb = re_log.size(); wb = we_log.size();
        wbuf[0] = 8'h00; wbuf[1] = 8'h00;
        xfer(8'h03, 16'h1234, 2);
        chk("rd1_byte0", rbuf[0], 8'h5A);
        chk("rd1_byte1", rbuf[1], 8'hC3);
        chk("rd1_re0", re_at(rb), 16'h1234);
        chk("rd1_re1", re_at(rb + 1), 16'h1235);
        chk("rd1_no_we", we_log.size() - wb, 0);
        chk("rd1_oe_off", miso_oe, 0);
        chk("rd1_busy", busy, 0);

        // Read across the top of the address space.
        rb = re_log.size();
        xfer(8'h03, 16'hFFFF, 2);
        chk("rdw_re0", re_at(rb), 16'hFFFF);
        chk("rdw_re1", re_at(rb + 1), 16'h0000);
        chk("rdw_byte0", rbuf[0], ref_mem[16'hFFFF]);
        chk("rdw_byte1", rbuf[1], ref_mem[16'h0000]);

        // Three-byte write burst crossing a byte-address carry.
        wb = we_log.size();
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        xfer(8'h02, 16'h00FE, 3);
        chk("wrb_count", we_log.size() - wb, 3);
        for (int i = 0; i < 3; i++) begin
            ai = 16'h00FE + 16'(i);
            chk("wrb_addr", we_at(wb + i)[23:8], ai);
            chk("wrb_data", we_at(wb + i)[7:0], wbuf[i]);
            ref_mem[ai] = wbuf[i];
        end
        sync_env();

        // Unknown opcode followed by 24 clocks of traffic.
        rb = re_log.size(); wb = we_log.size(); oe0 = oe_cnt;
        wbuf[0] = 8'hFF;
        xfer(8'h9F, 16'h0302, 1);
        chk("ign_no_re", re_log.size() - rb, 0);
        chk("ign_no_we", we_log.size() - wb, 0);
        chk("ign_no_oe", oe_cnt - oe0, 0);
        chk("ign_busy", busy, 0);

        // Write aborted after 5 data bits.
        wb = we_log.size();
        begin_xfer();
        spi_bits(8'h02, 8, d);
        spi_bits(8'h40, 8, d);
        spi_bits(8'h00, 8, d);
        spi_bits(8'hFF, 5, d);
        end_xfer();
        chk("part_no_we", we_log.size() - wb, 0);
        chk("part_busy", busy, 0);

        // Random mixed transactions against the reference image.
        for (int t = 0; t < 10; t++) begin
            is_rd = 1'($urandom_range(0, 1));
            a = (t == 4) ? 16'hFFFE : 16'($urandom_range(0, 65535));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            rb = re_log.size(); wb = we_log.size();
            if (is_rd) begin
                xfer(8'h03, a, n);
                chk("rnd_rd_no_we", we_log.size() - wb, 0);
                for (int i = 0; i < n; i++) begin
                    ai = a + 16'(i);
                    chk("rnd_rd_addr", re_at(rb + i), ai);
                    chk("rnd_rd_data", rbuf[i], ref_mem[ai]);
                end
            end else begin
                xfer(8'h02, a, n);
                chk("rnd_wr_count", we_log.size() - wb, n);
                chk("rnd_wr_no_re", re_log.size() - rb, 0);
                for (int i = 0; i < n; i++) begin
                    ai = a + 16'(i);
                    chk("rnd_wr_addr", we_at(wb + i)[23:8], ai);
                    chk("rnd_wr_data", we_at(wb + i)[7:0], wbuf[i]);
                    ref_mem[ai] = wbuf[i];
                end
                sync_env();
            end
        end

        // Reset in the middle of a read burst.
        a = 16'h2468;
        begin_xfer();
        spi_bits(8'h03, 8, d);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
        spi_bits(8'h00, 8, d);
        chk("rstmid_byte0", d, ref_mem[a]);
        spi_bits(8'h00, 4, d);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_oe", miso_oe, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_re", mem_re, 0);
        chk("rstmid_miso", miso, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rb = re_log.size();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstmid_no_re_after", re_log.size() - rb, 0);
        chk("rstmid_idle", busy, 0);
        rb = re_log.size();
        xfer(8'h03, 16'h0100, 2);
        chk("after_rst_re0", re_at(rb), 16'h0100);
        chk("after_rst_byte0", rbuf[0], ref_mem[16'h0100]);
        chk("after_rst_byte1", rbuf[1], ref_mem[16'h0101]);

        chk("invariants", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
